// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus: instruction-memory req/ack, branch redirect and the decode valid/ready port.
// master = fetch queue, slave = the memory/EX/decode side.
interface instr_fetch_queue_if;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemAck;
  logic [31:0] MemRData;
  logic        BranchTaken;
  logic [31:0] BranchAddr;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] InstrOut;
  logic [31:0] PCAddrInc;

  modport master (
    output MemReq, MemAddr, InstrValid, InstrOut, PCAddrInc,
    input  MemAck, MemRData, BranchTaken, BranchAddr, InstrReady
  );
  modport slave (
    input  MemReq, MemAddr, InstrValid, InstrOut, PCAddrInc,
    output MemAck, MemRData, BranchTaken, BranchAddr, InstrReady
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// PC owner + single-outstanding fetcher + DEPTH-entry instruction FIFO toward decode.
// Optional IFQ_BYPASS_EN: forward an ack straight to decode when the queue is empty.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 Clock,
  input  logic                 Reset,
  instr_fetch_queue_if.master  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d, addr_q, addr_d, pc_inc;
  logic [CW-1:0] count_q, count_d, cnt_new;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [63:0]   mem_q [DEPTH];
  logic [63:0]   head;
  logic          push, pop, fifo_vld, byp_vld, byp_take, req;
  logic          unused_baddr_lo;

  assign unused_baddr_lo = ^bus.BranchAddr[1:0];
  assign pc_inc   = pc_q + 32'd4;
  assign fifo_vld = (count_q != '0);
  assign head     = mem_q[rd_ptr_q];
  assign pop      = fifo_vld && bus.InstrReady;

`ifdef IFQ_BYPASS_EN
  assign byp_vld = !fifo_vld && (state_q == S_WAIT) && bus.MemAck && !bus.BranchTaken;
`else
  assign byp_vld = 1'b0;
`endif
  assign byp_take = byp_vld && bus.InstrReady;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    push     = 1'b0;
    cnt_new  = count_q - CW'(pop);
    case (state_q)
      S_IDLE: if (!bus.BranchTaken && count_q < FULL) begin
        state_d = S_WAIT;
        addr_d  = pc_q;
      end
      S_WAIT: begin
        if (bus.BranchTaken) begin
          // An un-acked request must stay up; its data is thrown away later.
          state_d = bus.MemAck ? S_IDLE : S_DISCARD;
        end else if (bus.MemAck) begin
          push    = !byp_take;
          pc_d    = pc_inc;
          cnt_new = count_q - CW'(pop) + CW'(push);
          if (cnt_new < FULL) addr_d = pc_inc;
          else                state_d = S_IDLE;
        end
      end
      S_DISCARD: if (bus.MemAck) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Redirect overrides any same-cycle push/pop and empties the queue.
    if (bus.BranchTaken) begin
      pc_d     = {bus.BranchAddr[31:2], 2'b00};
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d = count_q + CW'(push) - CW'(pop);
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset && push) mem_q[wr_ptr_q] <= {bus.MemRData, pc_inc};
  end

  // Outputs forced low while Reset is high, even before the first edge.
  always_comb begin
    req            = !Reset && (state_q != S_IDLE);
    bus.MemReq     = req;
    bus.MemAddr    = req ? addr_q : 32'd0;
    bus.InstrValid = !Reset && (fifo_vld || byp_vld);
    bus.InstrOut   = 32'd0;
    bus.PCAddrInc  = 32'd0;
    if (!Reset) begin
      if (fifo_vld) begin
        bus.InstrOut  = head[63:32];
        bus.PCAddrInc = head[31:0];
      end else if (byp_vld) begin
        bus.InstrOut  = bus.MemRData;
        bus.PCAddrInc = pc_inc;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed vector bench for instr_fetch_queue: per-cycle input/expected-output table
// plus a hand-written reset-release sequence.
module tb_instr_fetch_queue;
  logic Clock, Reset;
  instr_fetch_queue_if bus();

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .Clock(Clock), .Reset(Reset), .bus(bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic        rst, ack;
    logic [31:0] rdata;
    logic        br;
    logic [31:0] baddr;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_out, e_pc;
  } vec_t;

  vec_t tv[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic r, input logic a, input logic [31:0] d, input logic b,
                     input logic [31:0] ba, input logic y, input logic eq, input logic [31:0] ea,
                     input logic ev, input logic [31:0] eo, input logic [31:0] ep);
    vec_t v;
    v.rst = r; v.ack = a; v.rdata = d; v.br = b; v.baddr = ba; v.rdy = y;
    v.e_req = eq; v.e_addr = ea; v.e_vld = ev; v.e_out = eo; v.e_pc = ep;
    tv.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic run_table();
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge Clock);
      Reset = tv[i].rst;
      bus.MemAck = tv[i].ack;
      bus.MemRData = tv[i].rdata;
      bus.BranchTaken = tv[i].br;
      bus.BranchAddr = tv[i].baddr;
      bus.InstrReady = tv[i].rdy;
      #1;
      check("MemReq",     i, {31'd0, bus.MemReq},     {31'd0, tv[i].e_req});
      check("MemAddr",    i, bus.MemAddr,              tv[i].e_addr);
      check("InstrValid", i, {31'd0, bus.InstrValid}, {31'd0, tv[i].e_vld});
      check("InstrOut",   i, bus.InstrOut,             tv[i].e_out);
      check("PCAddrInc",  i, bus.PCAddrInc,            tv[i].e_pc);
    end
  endtask

  initial begin
    int n;
    Reset = 1'b1;
    bus.MemAck = 1'b0; bus.MemRData = '0; bus.BranchTaken = 1'b0;
    bus.BranchAddr = '0; bus.InstrReady = 1'b0;

`ifndef IFQ_BYPASS_EN
    // rst ack rdata b baddr rdy | req addr vld out pcinc
    add(1,0,32'h0,0,32'h0,0,        0,32'h0,0,32'h0,32'h0);               // reset
    add(0,1,32'h0,0,32'h0,1,        0,32'h0,0,32'h0,32'h0);               // IDLE ignores ack
    add(0,1,32'hC0DE_0000,0,32'h0,1, 1,32'h0,0,32'h0,32'h0);              // 1-cycle fetch @0
    add(0,1,32'hC0DE_0004,0,32'h0,1, 1,32'h4,1,32'hC0DE_0000,32'h4);      // k+1 valid
    add(0,1,32'hC0DE_0008,0,32'h0,1, 1,32'h8,1,32'hC0DE_0004,32'h8);
    add(0,1,32'hC0DE_000C,0,32'h0,0, 1,32'hC,1,32'hC0DE_0008,32'hC);      // decode stalls
    add(0,1,32'hC0DE_0010,0,32'h0,0, 1,32'h10,1,32'hC0DE_0008,32'hC);
    add(0,1,32'hC0DE_0014,0,32'h0,0, 1,32'h14,1,32'hC0DE_0008,32'hC);     // fills to 4
    add(0,1,32'h0,0,32'h0,0,        0,32'h0,1,32'hC0DE_0008,32'hC);       // full: no req
    add(0,1,32'h0,0,32'h0,1,        0,32'h0,1,32'hC0DE_0008,32'hC);       // one pop
    add(0,0,32'h0,0,32'h0,0,        0,32'h0,1,32'hC0DE_000C,32'h10);
    add(0,0,32'h0,0,32'h0,0,        1,32'h18,1,32'hC0DE_000C,32'h10);     // reissue @0x18
    add(0,0,32'h0,0,32'h0,0,        1,32'h18,1,32'hC0DE_000C,32'h10);     // held stable
    add(0,0,32'h0,0,32'h0,0,        1,32'h18,1,32'hC0DE_000C,32'h10);
    add(0,1,32'hC0DE_0018,0,32'h0,0, 1,32'h18,1,32'hC0DE_000C,32'h10);    // late ack
    add(0,0,32'h0,0,32'h0,1,        0,32'h0,1,32'hC0DE_000C,32'h10);
    add(0,0,32'h0,0,32'h0,1,        0,32'h0,1,32'hC0DE_0010,32'h14);
    add(0,1,32'hDEAD_BEEF,1,32'h103,0, 1,32'h1C,1,32'hC0DE_0014,32'h18);  // branch+ack
    add(0,0,32'h0,0,32'h0,0,        0,32'h0,0,32'h0,32'h0);               // flushed
    add(0,0,32'h0,0,32'h0,0,        1,32'h100,0,32'h0,32'h0);             // target 0x100
    add(0,0,32'h0,1,32'h207,0,      1,32'h100,0,32'h0,32'h0);             // branch, no ack
    add(0,0,32'h0,0,32'h0,0,        1,32'h100,0,32'h0,32'h0);             // DISCARD holds
    add(0,1,32'hBAD0_0100,0,32'h0,0, 1,32'h100,0,32'h0,32'h0);            // dropped
    add(0,0,32'h0,0,32'h0,0,        0,32'h0,0,32'h0,32'h0);
    add(0,1,32'h1111_2222,0,32'h0,0, 1,32'h204,0,32'h0,32'h0);
    add(0,0,32'h0,0,32'h0,0,        1,32'h208,1,32'h1111_2222,32'h208);
    add(0,0,32'h0,1,32'h500,0,      1,32'h208,1,32'h1111_2222,32'h208);   // pop not honoured
    add(0,0,32'h0,1,32'hFFFF_FFFF,0, 1,32'h208,0,32'h0,32'h0);            // 2nd redirect
    add(0,1,32'h0BAD_0BAD,0,32'h0,0, 1,32'h208,0,32'h0,32'h0);
    add(0,0,32'h0,0,32'h0,0,        0,32'h0,0,32'h0,32'h0);
    add(0,1,32'hABCD_0001,0,32'h0,0, 1,32'hFFFF_FFFC,0,32'h0,32'h0);      // last word
    add(0,0,32'h0,0,32'h0,1,        1,32'h0,1,32'hABCD_0001,32'h0);       // PC wraps
    add(0,0,32'h0,0,32'h0,1,        1,32'h0,0,32'h0,32'h0);
    add(1,1,32'h0,0,32'h0,1,        0,32'h0,0,32'h0,32'h0);               // outputs 0 in reset
    add(0,0,32'h0,0,32'h0,0,        0,32'h0,0,32'h0,32'h0);
`else
    add(1,0,32'h0,0,32'h0,0,        0,32'h0,0,32'h0,32'h0);
    add(0,1,32'h0,0,32'h0,1,        0,32'h0,0,32'h0,32'h0);
    add(0,1,32'h5555_0000,0,32'h0,1, 1,32'h0,1,32'h5555_0000,32'h4);      // bypass, consumed
    add(0,0,32'h0,0,32'h0,1,        1,32'h4,0,32'h0,32'h0);               // nothing queued
    add(0,1,32'h5555_0004,0,32'h0,0, 1,32'h4,1,32'h5555_0004,32'h8);      // bypass, stalled
    add(0,0,32'h0,0,32'h0,0,        1,32'h8,1,32'h5555_0004,32'h8);       // was pushed
    add(0,1,32'h5555_0008,0,32'h0,1, 1,32'h8,1,32'h5555_0004,32'h8);      // queue non-empty
    add(0,0,32'h0,0,32'h0,1,        1,32'hC,1,32'h5555_0008,32'hC);
    add(0,0,32'h0,0,32'h0,1,        1,32'hC,0,32'h0,32'h0);
`endif
    run_table();

    // Reset release: first request appears after one edge with Reset low.
    @(negedge Clock);
    Reset = 1'b1; bus.MemAck = 1'b0; bus.BranchTaken = 1'b0; bus.InstrReady = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;
    n = 0;
    while (!bus.MemReq && n < 8) begin
      @(negedge Clock);
      n++;
    end
    check("first_req_seen",    0, {31'd0, bus.MemReq}, 32'd1);
    check("first_req_latency", 0, n, 32'd1);
    check("first_req_addr",    0, bus.MemAddr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
